// File: rtl/alu_pkg.sv
//==============================================================
// alu_pkg : op codes, FSM states and op-decode helper for alu_seq
// Rev 1.0
//==============================================================
`default_nettype none

package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_NOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SLTU = 4'b0111,
      OP_SRL  = 4'b1000,
      OP_SRA  = 4'b1001,
      OP_SLT  = 4'b1010,
      OP_MUL  = 4'b1011
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

   // Codes above OP_MUL have no defined operation.
   function automatic logic op_defined(input logic [3:0] op);
      return (op <= OP_MUL);
   endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
//==============================================================
// alu_mul_iter : shift-add multiplier, WIDTH iterations, low WIDTH bits
// Rev 1.0
//==============================================================
`default_nettype none

module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH);

   logic             busy_q,   busy_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q,    acc_d;
   logic [WIDTH-1:0] acc_step;
   logic             last;

   // The final iteration is combinational so the owner can load the
   // product on the same edge the counter expires.
   always_comb begin
      acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
      last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
      busy_d   = busy_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      if (start) begin
         busy_d   = 1'b1;
         cnt_d    = '0;
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
      end else if (busy_q) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (last) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end else begin
            cnt_d  = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else begin
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
      end
   end

   assign done    = last;
   assign product = acc_step;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
//==============================================================
// alu_seq : valid/ready ALU, single-cycle ops plus optional iterative MUL
// Rev 1.0
//==============================================================
`default_nettype none

module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             ovf,
   output logic             illegal
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
   logic             illegal_q, illegal_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [SHW-1:0]   shamt;

   logic             accept;
   logic             is_mul;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   always_comb begin
      sum     = a + b;
      diff    = a - b;
      shamt   = b[SHW-1:0];
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = !op_defined(op);
      case (op)
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_NOR:  alu_res = ~(a | b);
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         // SUB adds ~b+1, so the effective b sign is inverted.
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLL:  alu_res = a << shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
         OP_MUL:  alu_ill = (MUL_EN == 0);
         default: alu_res = '0;
      endcase
   end

   assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign is_mul    = (op == OP_MUL) && (MUL_EN != 0);
   assign mul_start = accept && is_mul;

   generate
      if (MUL_EN != 0) begin : g_mul
         alu_mul_iter #(
            .WIDTH   (WIDTH)
         ) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (mul_start),
            .a       (a),
            .b       (b),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      illegal_d   = illegal_q;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         if (is_mul) begin
            state_d = MUL;
         end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            illegal_d   = alu_ill;
         end
      end
      if ((state_q == MUL) && mul_done) begin
         state_d     = IDLE;
         out_valid_d = 1'b1;
         result_d    = mul_product;
         zero_d      = (mul_product == '0);
         ovf_d       = 1'b0;
         illegal_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;
   assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be a power of two, >= 8.
REQ-002 Parameter MUL_EN, default 1: 1 = iterative multiply present; 0 = OP_MUL treated as illegal.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_valid  in  1  operation request valid.
REQ-006 in_ready  out  1  block accepts request this cycle.
REQ-007 op  in  4  operation code (alu_op_e).
REQ-008 a, b  in  WIDTH each  operands.
REQ-009 out_valid  out  1  result/flags valid.
REQ-010 out_ready  in  1  consumer takes result this cycle.
REQ-011 result  out  WIDTH  registered result.
REQ-012 zero  out  1  result == 0.
REQ-013 ovf  out  1  signed overflow (ADD/SUB only, else 0).
REQ-014 illegal  out  1  op undefined, or MUL with MUL_EN=0.

Function
REQ-015 Op codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLTU (unsigned a<b → 1 else 0), 0011 XOR, 0100 NOR, 0101 SLL, 1000 SRL, 1001 SRA, 1010 SLT (signed), 1011 MUL (low WIDTH bits of a*b); others illegal.
REQ-016 Shift amount SHALL be b[$clog2(WIDTH)-1:0]; upper bits of b ignored.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; ovf = sign of a,b(eff) equal and result sign differs.
REQ-018 Illegal op SHALL complete with single-cycle latency: result 0, zero 1, ovf 0, illegal 1.
REQ-019 Transfer occurs on in_valid & in_ready (accept) and on out_valid & out_ready (retire).
REQ-020 FSM states IDLE, MUL; in_ready = (state==IDLE) & (!out_valid | out_ready).
REQ-021 Non-MUL accepted at edge N → out_valid high from edge N+1; back-to-back accepts SHALL sustain one op per cycle while out_ready high.
REQ-022 MUL accepted at edge N → state MUL, shift-add counter runs WIDTH iterations; out_valid high from edge N+WIDTH; state returns IDLE same edge.
REQ-023 While out_valid & !out_ready: result/flags SHALL hold stable; in_ready low.
REQ-024 Retire without new accept same edge SHALL clear out_valid; simultaneous retire+accept SHALL load new result with out_valid staying high.
REQ-025 in_valid while in_ready low SHALL be ignored; operands need not be held by the block.
REQ-026 Operands of an accepted MUL SHALL be captured; later changes on a, b, op have no effect.

Reset
REQ-027 rst_n low SHALL asynchronously force: state IDLE, counter 0, out_valid 0, result 0, zero 0, ovf 0, illegal 0.
REQ-028 Reset during MUL SHALL abort it; no result is produced after release.
REQ-029 in_ready SHALL be high in first cycle after reset release.

Structure
REQ-030 Package alu_pkg SHALL hold alu_op_e (4-bit enum, codes per REQ-015) and alu_state_e (IDLE, MUL).
REQ-031 Iterative multiplier SHALL be sub-module alu_mul_iter (start, done, WIDTH-parametrised), instantiated only when MUL_EN=1.
REQ-032 Combinational single-cycle op datapath SHALL remain in alu_seq.

Verification
REQ-033 Reset, then ADD a=0x7FFFFFFF b=1, out_ready=1 → next cycle result 0x80000000, ovf 1, zero 0.
REQ-034 SUB a=5 b=5 → result 0, zero 1; SLT a=0xFFFFFFFF b=1 → 1; SLTU same operands → 0; SRA a=0x80000000 b=35 → 0xF0000000.
REQ-035 MUL a=0x12345 b=0x100 → in_ready low for WIDTH cycles, result 0x01234500 with out_valid at N+32.
REQ-036 10 back-to-back ADDs, out_ready held 0 after first → result stable, in_ready low; release → one retire per cycle, no loss or duplication.
REQ-037 rst_n low at iteration 10 of MUL → outputs zero immediately; after release no out_valid until new request.
REQ-038 op=1111, and MUL with MUL_EN=0 → illegal 1, result 0, latency 1.
